// File: rtl/music_box_player.sv
// Programmable music box sequencer.
// A writable note table maps note codes to tone half-periods, and a pattern
// memory holds the melody. While playing, a step timer walks the pattern at a
// tempo of (tempo+1) clocks per step. A divider toggles 'tone' every H+1
// clocks for the latched half-period H. Code 0 or H==0 plays as a rest.

module music_box_player #(
    parameter  int STEPS   = 16,
    parameter  int CODE_W  = 4,
    parameter  int DIV_W   = 16,
    parameter  int TEMPO_W = 20,
    localparam int SW      = $clog2(STEPS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tbl_we,
    input  logic [CODE_W-1:0]  tbl_addr,
    input  logic [DIV_W-1:0]   tbl_data,
    input  logic               pat_we,
    input  logic [SW-1:0]      pat_addr,
    input  logic [CODE_W-1:0]  pat_data,
    input  logic [TEMPO_W-1:0] tempo,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    output logic               tone,
    output logic               busy,
    output logic [SW-1:0]      step_idx,
    output logic [CODE_W-1:0]  cur_code,
    output logic               done
);

    localparam int              NOTES     = 2 ** CODE_W;
    localparam logic [SW-1:0]   LAST_STEP = SW'(STEPS - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t state, next_state;

    logic [DIV_W-1:0]   note_tbl [NOTES];
    logic [CODE_W-1:0]  pattern  [STEPS];

    logic [DIV_W-1:0]   half;
    logic [DIV_W-1:0]   div_cnt;
    logic [TEMPO_W-1:0] step_cnt;

    logic               load_step;
    logic               finish;
    logic               abort;
    logic [SW-1:0]      fetch_idx;
    logic [CODE_W-1:0]  fetch_code;
    logic [DIV_W-1:0]   fetch_half;
    logic               is_rest;

    // The first step always fetches entry 0; later steps fetch the next index.
    // STEPS is a power of two, so the increment wraps to 0 after the last step.
    assign fetch_idx  = (state == IDLE) ? '0 : step_idx + SW'(1);
    assign fetch_code = pattern[fetch_idx];
    assign fetch_half = note_tbl[fetch_code];
    assign is_rest    = (cur_code == '0) || (half == '0);
    assign busy       = (state == PLAY);

    // Note table: host writes land on the strobe edge; reset clears all pitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NOTES; i++) begin
                note_tbl[i] <= '0;
            end
        end else if (tbl_we) begin
            note_tbl[tbl_addr] <= tbl_data;
        end
    end

    // Pattern memory: host writes land on the strobe edge; reset clears the melody.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                pattern[i] <= '0;
            end
        end else if (pat_we) begin
            pattern[pat_addr] <= pat_data;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: stop beats a step boundary, the last step either wraps or finishes.
    always_comb begin
        next_state = state;
        load_step  = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    next_state = PLAY;
                    load_step  = 1'b1;
                end
            end
            PLAY: begin
                if (stop) begin
                    next_state = IDLE;
                    abort      = 1'b1;
                end else if (step_cnt == '0) begin
                    if (step_idx == LAST_STEP && !loop) begin
                        next_state = IDLE;
                        finish     = 1'b1;
                    end else begin
                        load_step = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Step timer, per-step latches and tone divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_idx <= '0;
            cur_code <= '0;
            half     <= '0;
            div_cnt  <= '0;
            step_cnt <= '0;
            tone     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load_step) begin
                step_idx <= fetch_idx;
                cur_code <= fetch_code;
                half     <= fetch_half;
                div_cnt  <= fetch_half;
                step_cnt <= tempo;
                tone     <= 1'b0;
            end else if (finish || abort) begin
                step_idx <= '0;
                cur_code <= '0;
                div_cnt  <= '0;
                step_cnt <= '0;
                tone     <= 1'b0;
                done     <= finish;
            end else if (state == PLAY) begin
                step_cnt <= step_cnt - TEMPO_W'(1);
                if (is_rest) begin
                    tone <= 1'b0;
                end else if (div_cnt == '0) begin
                    tone    <= ~tone;
                    div_cnt <= half;
                end else begin
                    div_cnt <= div_cnt - DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_music_box_player.sv
// Self-checking bench for music_box_player. A time-based reference model
// derives the expected tone from the offset into the current step.

module tb_music_box_player;

    localparam int STEPS   = 4;
    localparam int CODE_W  = 4;
    localparam int DIV_W   = 16;
    localparam int TEMPO_W = 20;
    localparam int SW      = $clog2(STEPS);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               tbl_we = 1'b0;
    logic [CODE_W-1:0]  tbl_addr = '0;
    logic [DIV_W-1:0]   tbl_data = '0;
    logic               pat_we = 1'b0;
    logic [SW-1:0]      pat_addr = '0;
    logic [CODE_W-1:0]  pat_data = '0;
    logic [TEMPO_W-1:0] tempo = '0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               loop = 1'b0;
    logic               tone;
    logic               busy;
    logic [SW-1:0]      step_idx;
    logic [CODE_W-1:0]  cur_code;
    logic               done;

    int tests_run = 0;
    int fails     = 0;
    int done_cnt  = 0;
    int busy_cnt  = 0;
    int tone_hi   = 0;

    // Reference model: memory images plus the current step's latched view.
    int m_tbl [2**CODE_W];
    int m_pat [STEPS];
    bit m_busy  = 1'b0;
    bit m_done  = 1'b0;
    int m_step  = 0;
    int m_code  = 0;
    int m_half  = 0;
    int m_n     = 0;
    int m_tempo = 0;

    music_box_player #(
        .STEPS(STEPS), .CODE_W(CODE_W), .DIV_W(DIV_W), .TEMPO_W(TEMPO_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
        .tempo(tempo), .start(start), .stop(stop), .loop(loop),
        .tone(tone), .busy(busy), .step_idx(step_idx),
        .cur_code(cur_code), .done(done)
    );

    always #5 clk = ~clk;

    // Enter step k: snapshot its code, its pitch and the tempo for this step.
    task automatic modelBeginStep(input int k);
        m_busy  = 1'b1;
        m_step  = k;
        m_code  = m_pat[k];
        m_half  = m_tbl[m_code];
        m_tempo = int'(tempo);
        m_n     = 0;
    endtask

    // The tone is a pure function of how far we are into the step.
    function automatic logic expTone();
        if (!m_busy || m_code == 0 || m_half == 0) return 1'b0;
        return ((m_n / (m_half + 1)) % 2) == 1;
    endfunction

    // Reference model advances once per clock edge; writes land after the fetch.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**CODE_W; i++) m_tbl[i] = 0;
            for (int i = 0; i < STEPS; i++) m_pat[i] = 0;
            m_busy = 1'b0; m_done = 1'b0; m_step = 0; m_code = 0;
            m_half = 0; m_n = 0; m_tempo = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start && !stop) modelBeginStep(0);
            end else if (stop) begin
                m_busy = 1'b0; m_step = 0; m_code = 0;
            end else begin
                m_n++;
                if (m_n == m_tempo + 1) begin
                    if (m_step == STEPS - 1 && !loop) begin
                        m_busy = 1'b0; m_done = 1'b1; m_step = 0; m_code = 0;
                    end else begin
                        modelBeginStep((m_step + 1) % STEPS);
                    end
                end
            end
            if (tbl_we) m_tbl[tbl_addr] = int'(tbl_data);
            if (pat_we) m_pat[pat_addr] = int'(pat_data);
        end
    end

    task automatic checkOutput();
        logic e_tone;
        e_tone = expTone();
        tests_run++;
        assert (tone === e_tone) else begin
            fails++;
            $error("[TB] FAIL tone t=%0t observed=%0b expected=%0b", $time, tone, e_tone);
        end
        tests_run++;
        assert (busy === m_busy) else begin
            fails++;
            $error("[TB] FAIL busy t=%0t observed=%0b expected=%0b", $time, busy, m_busy);
        end
        tests_run++;
        assert (done === m_done) else begin
            fails++;
            $error("[TB] FAIL done t=%0t observed=%0b expected=%0b", $time, done, m_done);
        end
        tests_run++;
        assert (step_idx === SW'(m_step)) else begin
            fails++;
            $error("[TB] FAIL step_idx t=%0t observed=%0d expected=%0d", $time, step_idx, m_step);
        end
        if (m_busy) begin
            tests_run++;
            assert (cur_code === CODE_W'(m_code)) else begin
                fails++;
                $error("[TB] FAIL cur_code t=%0t observed=%0d expected=%0d", $time, cur_code, m_code);
            end
        end
    endtask

    // One clock: edge, then sample on the falling edge against the model.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (tone) tone_hi++;
    endtask

    task automatic applyStimulus(input logic s, input logic sp, input logic lp, input int tmp);
        start = s;
        stop  = sp;
        loop  = lp;
        tempo = TEMPO_W'(tmp);
    endtask

    task automatic writeTbl(input int a, input int d);
        tbl_we = 1'b1; tbl_addr = CODE_W'(a); tbl_data = DIV_W'(d);
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic writePat(input int a, input int d);
        pat_we = 1'b1; pat_addr = SW'(a); pat_data = CODE_W'(d);
        tick();
        pat_we = 1'b0;
    endtask

    task automatic directed(input string tag, input int observed, input int expected);
        tests_run++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Bounded wait for a given step index; an expired budget counts as a failure.
    task automatic waitStep(input int idx, input int budget);
        int n;
        n = 0;
        while (int'(step_idx) != idx && n < budget) begin
            tick();
            n++;
        end
        directed("wait_step_reached", int'(step_idx), idx);
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        directed("wait_idle_reached", int'(busy), 0);
    endtask

    initial begin
        int rise_at;
        int codes [STEPS];

        // Power-on reset held across a few edges.
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput();
        tick();

        // Single note: H=2, all steps code 1, tempo 11, no loop.
        writeTbl(1, 2);
        for (int i = 0; i < STEPS; i++) writePat(i, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 11);
        busy_cnt = 0; done_cnt = 0;
        tick();
        start = 1'b0;
        rise_at = -1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (tone && rise_at < 0) rise_at = i;
        end
        directed("first_rise_edges", rise_at, 3);
        waitIdle(200);
        directed("single_busy_clocks", busy_cnt, 48);
        directed("single_done_pulses", done_cnt, 1);
        tick();

        // Rest and pitch change: pattern {1,0,2,0}, tempo 15.
        writeTbl(1, 1);
        writeTbl(2, 3);
        writePat(0, 1); writePat(1, 0); writePat(2, 2); writePat(3, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 15);
        tick();
        start = 1'b0;
        codes[0] = int'(cur_code);
        for (int k = 1; k < STEPS; k++) begin
            repeat (16) tick();
            codes[k] = int'(cur_code);
        end
        directed("code_step0", codes[0], 1);
        directed("code_step1", codes[1], 0);
        directed("code_step2", codes[2], 2);
        directed("code_step3", codes[3], 0);
        waitIdle(100);

        // Loop wraps without done; stop in step 2 aborts silently.
        applyStimulus(1'b1, 1'b0, 1'b1, 3);
        done_cnt = 0;
        tick();
        start = 1'b0;
        repeat (20) tick();
        directed("loop_still_busy", int'(busy), 1);
        directed("loop_wrapped_idx", int'(step_idx), 1);
        directed("loop_no_done", done_cnt, 0);
        waitStep(2, 40);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        directed("stop_busy_falls", int'(busy), 0);
        repeat (10) tick();
        directed("stop_no_done", done_cnt, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        directed("start_stop_idle", int'(busy), 0);
        tick();

        // Live writes during step 0 plus an ignored start in step 1.
        writeTbl(1, 2);
        writeTbl(3, 4);
        for (int i = 0; i < STEPS; i++) writePat(i, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 11);
        tick();
        start = 1'b0;
        repeat (2) tick();
        tbl_we = 1'b1; tbl_addr = 4'd1; tbl_data = 16'd5;
        pat_we = 1'b1; pat_addr = 2'd2; pat_data = 4'd3;
        tick();
        tbl_we = 1'b0; pat_we = 1'b0;
        waitStep(1, 40);
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        directed("start_ignored_idx", int'(step_idx), 1);
        waitStep(2, 40);
        directed("live_pat_code", int'(cur_code), 3);
        waitIdle(100);

        // Asynchronous reset mid-playback, then an all-rest melody.
        applyStimulus(1'b1, 1'b0, 1'b1, 5);
        tick();
        start = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        directed("rst_tone", int'(tone), 0);
        directed("rst_busy", int'(busy), 0);
        directed("rst_done", int'(done), 0);
        directed("rst_step_idx", int'(step_idx), 0);
        directed("rst_cur_code", int'(cur_code), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 2);
        busy_cnt = 0; done_cnt = 0; tone_hi = 0;
        tick();
        start = 1'b0;
        waitIdle(100);
        directed("rest_busy_clocks", busy_cnt, STEPS * 3);
        directed("rest_tone_high", tone_hi, 0);
        directed("rest_done_pulses", done_cnt, 1);

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 1500; c++) begin
            tbl_we   = ($urandom_range(0, 3) == 0);
            tbl_addr = CODE_W'($urandom_range(0, 3));
            tbl_data = DIV_W'($urandom_range(0, 4));
            pat_we   = ($urandom_range(0, 3) == 0);
            pat_addr = SW'($urandom_range(0, STEPS - 1));
            pat_data = CODE_W'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
                          1'($urandom_range(0, 1)), int'($urandom_range(0, 9)));
            tick();
        end
        tbl_we = 1'b0; pat_we = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
